// File: rtl/pattern_sweep_capture.sv
// Exhaustive pattern sweep: drives every WIDTH-bit pattern, captures the 1-bit response
// into a truth table and (with SWEEP_MISR_EN defined) compresses it into a MISR signature.
module pattern_sweep_capture #(
    parameter int unsigned     WIDTH = 3,
    parameter int unsigned     HOLD  = 1,
    parameter int unsigned     SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dut_resp,
    output logic [WIDTH-1:0]        pat_out,
    output logic                    busy,
    output logic                    done,
    output logic [(2**WIDTH)-1:0]   resp_tab,
    output logic [SIG_W-1:0]        sig
);

    localparam int unsigned NPAT = 2 ** WIDTH;
    localparam int unsigned HCW  = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD);
    localparam logic [WIDTH-1:0] PAT_LAST  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pat,   w_pat_nxt;
    logic [HCW-1:0]   r_hold,  w_hold_nxt;
    logic [NPAT-1:0]  r_tab,   w_tab_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
`ifdef SWEEP_MISR_EN
    logic [SIG_W-1:0] r_sig,   w_sig_nxt;
`endif

    // Next-state and next-output logic; abort has priority over the final capture
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_hold_nxt  = r_hold;
        w_tab_nxt   = r_tab;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef SWEEP_MISR_EN
        w_sig_nxt   = r_sig;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_pat_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_tab_nxt   = '0;
                    w_busy_nxt  = 1'b1;
`ifdef SWEEP_MISR_EN
                    w_sig_nxt   = '0;
`endif
                end
            end
            S_APPLY: begin
                w_busy_nxt = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_hold == HOLD_LAST) begin
                    w_hold_nxt         = '0;
                    w_tab_nxt[r_pat]   = dut_resp;
`ifdef SWEEP_MISR_EN
                    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                              ^ (r_sig[SIG_W-1] ? POLY : '0)
                              ^ SIG_W'(dut_resp);
`endif
                    if (r_pat == PAT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_pat_nxt = r_pat + WIDTH'(1);
                    end
                end else begin
                    w_hold_nxt = r_hold + HCW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_hold  <= '0;
            r_tab   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SWEEP_MISR_EN
            r_sig   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hold  <= w_hold_nxt;
            r_tab   <= w_tab_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef SWEEP_MISR_EN
            r_sig   <= w_sig_nxt;
`endif
        end
    end

    assign pat_out  = r_pat;
    assign busy     = r_busy;
    assign done     = r_done;
    assign resp_tab = r_tab;
`ifdef SWEEP_MISR_EN
    assign sig      = r_sig;
`else
    // Constant zero; POLY stays referenced so both builds share one parameter list
    assign sig      = POLY & '0;
`endif

endmodule
